uart_word_loader_rx: RTL and testbench
======================================

Name: uart_word_loader_rx

Overview:
- UART receiver that takes the serial instruction stream the boot loader sends over the instruction UART pin.
- Frame format: 8N1, LSB first, bytes sent little-endian per 32-bit word.
- Assembles every four received bytes into one 32-bit word and presents it with an incrementing word address on a valid/ready write port.
- Sits between the instruction UART pin and the ICCM write path, ahead of system reset release.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud, rounded up).
- DATA_WIDTH, 32, output word width; fixed at 32 (4 bytes).
- ADDR_WIDTH, 12, width of the word-address counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  loader enable; low forces the receiver idle.
- rx_i  in  1  asynchronous UART serial input; idle high.
- word_valid_o  out  1  assembled word available.
- word_ready_i  in  1  consumer accepts the word when high with word_valid_o.
- word_data_o  out  DATA_WIDTH  assembled word; byte k in bits [8k+7:8k].
- word_addr_o  out  ADDR_WIDTH  word index of word_data_o; equals count of accepted words.
- busy_o  out  1  high while the FSM is not in IDLE or a partial word is held.
- frame_err_o  out  1  one-cycle pulse on a stop-bit error.
- overrun_o  out  1  sticky; word completed while previous word was still pending.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - FSM goes to IDLE; bit and clock counters cleared.
  - Byte lane cleared to 0; word_addr_o = 0.
  - word_valid_o, word_data_o, frame_err_o, overrun_o all 0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame entirely.
- Input sync: rx_i passes through a 2-flop synchronizer; every use below refers to the synchronized value (rxs).
- FSM states: IDLE, START, DATA, STOP. One clock counter cnt.
- IDLE:
  - Requires en_i = 1.
  - On rxs = 0, clear cnt and go to START.
- START:
  - At cnt == (CLKS_PER_BIT-1)/2, sample rxs.
  - rxs = 0: clear cnt, clear bit index, go to DATA.
  - rxs = 1: treat as a glitch and return to IDLE with no other effect.
- DATA:
  - At cnt == CLKS_PER_BIT-1, shift rxs into the byte LSB-first and clear cnt.
  - After bit index 7, go to STOP.
- STOP:
  - At cnt == CLKS_PER_BIT-1, sample rxs and go to IDLE.
  - rxs = 1: byte accepted; written to lane k; lane increments.
  - rxs = 0: frame_err_o pulses for 1 cycle; the byte and any partial word are discarded; lane resets to 0.
- en_i low:
  - FSM is forced to IDLE on the next edge.
  - Partial word and lane are cleared.
  - A pending word_valid_o, the address, and overrun_o are kept.
- Word completion: on acceptance of lane 3, the word is complete and lane wraps to 0.
  - word_valid_o = 0, or word_ready_i = 1 in the same cycle: load word_data_o and set word_valid_o the next cycle. word_addr_o reflects the accepted count.
  - word_valid_o = 1 and word_ready_i = 0: drop the new word, set overrun_o, and leave the pending word unchanged.
- Handshake:
  - Transfer happens on a cycle with word_valid_o & word_ready_i.
  - On transfer, word_addr_o increments; it wraps from 2^ADDR_WIDTH-1 to 0.
  - word_valid_o clears unless a new word loads in the same cycle.
  - word_data_o is stable while word_valid_o is high and not yet accepted.
- Latency: word_valid_o rises 1 cycle after the STOP sample of lane 3. From the rx_i edge there is an additional 2-cycle synchronizer delay.
- overrun_o clears only on reset.

Test Plan (CLKS_PER_BIT = 16 for simulation):
- Frames 0x13, 0x01, 0x20, 0x00 with word_ready_i = 1:
  - word_valid_o pulses with word_data_o = 0x00200113 and word_addr_o = 0.
  - word_addr_o = 1 afterwards.
  - frame_err_o and overrun_o stay 0.
- word_ready_i held 0; send 8 bytes (0x00200113 then 0x00000093):
  - First word is held and overrun_o = 1.
  - After raising word_ready_i, exactly one transfer occurs with 0x00200113, and word_addr_o = 1.
- rx_i low for 4 cycles and then high (shorter than a half bit): FSM returns to IDLE, no byte is accepted, busy_o returns to 0.
- Bytes 0x11, 0x22, then a frame of 0xAA with stop bit 0:
  - frame_err_o pulses for 1 cycle and there is no word.
  - Next 4 bytes 0x44, 0x33, 0x22, 0x11 give word 0x11223344 at the same address.
- rst_i asserted during bit 4 of byte 2:
  - All outputs become 0.
  - Next clean 4-byte sequence 0xEF, 0xBE, 0xAD, 0xDE gives 0xDEADBEEF at word_addr_o = 0.
- en_i = 0 while 4 valid frames are driven: no word_valid_o and no frame_err_o. After en_i = 1, 4 frames give one word.

Source files
------------

// File: rtl/uart_word_loader_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_loader_rx
//  Description : 8N1 UART receiver for the boot-loader instruction stream.
//                Packs four little-endian bytes into a 32-bit word and
//                offers it, with an incrementing word address, on a
//                valid/ready write port feeding the ICCM.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_word_loader_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  rx_i,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic [DATA_WIDTH-1:0] word_data_o,
  output logic [ADDR_WIDTH-1:0] word_addr_o,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic                  r_rx_meta;
  logic                  r_rx_sync;
  logic                  w_rxs;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [2:0]            r_bit_idx;
  logic [2:0]            w_bit_nxt;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_nxt;
  logic                  w_byte_ok;
  logic                  w_frame_err;

  logic [1:0]            r_lane;
  logic [DATA_WIDTH-9:0] r_partial;
  logic                  r_word_valid;
  logic [DATA_WIDTH-1:0] r_word_data;
  logic [ADDR_WIDTH-1:0] r_word_addr;
  logic                  r_frame_err;
  logic                  r_overrun;

  logic                  w_complete;
  logic                  w_xfer;
  logic                  w_load;

  // Two-flop synchronizer; presets to the idle-high line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rxs = r_rx_sync;

  // Receiver state register, bit timer, bit index and shift register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic: mid-bit start check, data sampling and stop check.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_byte_ok   = 1'b0;
    w_frame_err = 1'b0;
    if (!en_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (!w_rxs) w_state_nxt = S_START;
        end
        S_START: begin
          if (r_cnt == c_CNT_HALF) begin
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            // A line that has returned high by mid-start-bit was a glitch.
            w_state_nxt = w_rxs ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (r_cnt == c_CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {w_rxs, r_shift[7:1]};
            w_bit_nxt   = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
          end
        end
        S_STOP: begin
          if (r_cnt == c_CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
            if (w_rxs) w_byte_ok   = 1'b1;
            else       w_frame_err = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_complete = w_byte_ok && (r_lane == 2'd3);
  assign w_xfer     = r_word_valid && word_ready_i;
  assign w_load     = w_complete && (!r_word_valid || word_ready_i);

  // Byte-lane packing; a framing error or disable discards the partial word.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i || w_frame_err) begin
      r_lane    <= '0;
      r_partial <= '0;
    end else if (w_byte_ok) begin
      r_lane <= r_lane + 2'd1;
      case (r_lane)
        2'd0:    r_partial[7:0]   <= r_shift;
        2'd1:    r_partial[15:8]  <= r_shift;
        2'd2:    r_partial[23:16] <= r_shift;
        default: r_partial        <= '0;
      endcase
    end
  end

  // Output word register, address counter and sticky overrun flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_word_addr  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_xfer) r_word_addr <= r_word_addr + 1'b1;
      if (w_load) begin
        r_word_data  <= {r_shift, r_partial};
        r_word_valid <= 1'b1;
      end else begin
        // A finished word with the previous one still unaccepted is lost.
        if (w_complete) r_overrun    <= 1'b1;
        if (w_xfer)     r_word_valid <= 1'b0;
      end
    end
  end

  // Stop-bit error strobe, registered to a single-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_frame_err <= 1'b0;
    else       r_frame_err <= w_frame_err;
  end

  assign word_valid_o = r_word_valid;
  assign word_data_o  = r_word_data;
  assign word_addr_o  = r_word_addr;
  assign frame_err_o  = r_frame_err;
  assign overrun_o    = r_overrun;
  assign busy_o       = (r_state != S_IDLE) || (r_lane != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_uart_word_loader_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_word_loader_rx
//  Description : Directed self-checking bench for uart_word_loader_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_loader_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rx;
  logic        ready;
  logic        word_valid;
  logic [31:0] word_data;
  logic [11:0] word_addr;
  logic        busy;
  logic        frame_err;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] xfer_data[$];
  logic [11:0] xfer_addr[$];
  int          fe_cycles = 0;

  always #5 clk = ~clk;

  uart_word_loader_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (12)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .rx_i        (rx),
    .word_valid_o(word_valid),
    .word_ready_i(ready),
    .word_data_o (word_data),
    .word_addr_o (word_addr),
    .busy_o      (busy),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  // Record handshakes and error strobes away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid && ready) begin
        xfer_data.push_back(word_data);
        xfer_addr.push_back(word_addr);
      end
      if (frame_err) fe_cycles++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_frame(w[8*k +: 8], 1'b1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; rx = 1'b1; ready = 1'b1;
    tick(3);
    n_vec++; if (word_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", word_valid); n_err++; end
    n_vec++; if (word_data !== 32'h0) begin $display("FAIL rst_data: got %h want 0", word_data); n_err++; end
    n_vec++; if (word_addr !== 12'h0) begin $display("FAIL rst_addr: got %h want 0", word_addr); n_err++; end
    n_vec++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); n_err++; end
    n_vec++; if (frame_err !== 1'b0) begin $display("FAIL rst_ferr: got %b want 0", frame_err); n_err++; end
    n_vec++; if (overrun !== 1'b0) begin $display("FAIL rst_ovr: got %b want 0", overrun); n_err++; end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic;
    int n0;
    logic [31:0] d;
    logic [11:0] a;
    n0 = xfer_data.size();
    send_word(32'h0020_0113);
    tick(4);
    n_vec++; if (xfer_data.size() - n0 !== 1) begin $display("FAIL basic_count: got %0d want 1", xfer_data.size() - n0); n_err++; end
    d = (xfer_data.size() > n0) ? xfer_data[n0] : 32'hx;
    a = (xfer_addr.size() > n0) ? xfer_addr[n0] : 12'hx;
    n_vec++; if (d !== 32'h0020_0113) begin $display("FAIL basic_data: got %h want 00200113", d); n_err++; end
    n_vec++; if (a !== 12'h000) begin $display("FAIL basic_xaddr: got %h want 000", a); n_err++; end
    n_vec++; if (word_addr !== 12'h001) begin $display("FAIL basic_addr: got %h want 001", word_addr); n_err++; end
    n_vec++; if (word_valid !== 1'b0) begin $display("FAIL basic_valid: got %b want 0", word_valid); n_err++; end
    n_vec++; if (fe_cycles !== 0) begin $display("FAIL basic_ferr: got %0d want 0", fe_cycles); n_err++; end
    n_vec++; if (overrun !== 1'b0) begin $display("FAIL basic_ovr: got %b want 0", overrun); n_err++; end
  endtask

  task automatic test_back_to_back;
    int n0;
    logic [31:0] d;
    logic [11:0] a;
    n0 = xfer_data.size();
    send_word(32'h0000_0093);
    tick(4);
    n_vec++; if (xfer_data.size() - n0 !== 1) begin $display("FAIL b2b_count: got %0d want 1", xfer_data.size() - n0); n_err++; end
    d = (xfer_data.size() > n0) ? xfer_data[n0] : 32'hx;
    a = (xfer_addr.size() > n0) ? xfer_addr[n0] : 12'hx;
    n_vec++; if (d !== 32'h0000_0093) begin $display("FAIL b2b_data: got %h want 00000093", d); n_err++; end
    n_vec++; if (a !== 12'h001) begin $display("FAIL b2b_xaddr: got %h want 001", a); n_err++; end
    n_vec++; if (word_addr !== 12'h002) begin $display("FAIL b2b_addr: got %h want 002", word_addr); n_err++; end
  endtask

  task automatic test_overrun;
    int n0;
    logic [31:0] d;
    do_reset();
    ready = 1'b0;
    n0 = xfer_data.size();
    send_word(32'h0020_0113);
    n_vec++; if (word_valid !== 1'b1) begin $display("FAIL ovr_valid1: got %b want 1", word_valid); n_err++; end
    n_vec++; if (overrun !== 1'b0) begin $display("FAIL ovr_early: got %b want 0", overrun); n_err++; end
    send_word(32'h0000_0093);
    n_vec++; if (overrun !== 1'b1) begin $display("FAIL ovr_flag: got %b want 1", overrun); n_err++; end
    n_vec++; if (word_data !== 32'h0020_0113) begin $display("FAIL ovr_held: got %h want 00200113", word_data); n_err++; end
    ready = 1'b1;
    tick(6);
    n_vec++; if (xfer_data.size() - n0 !== 1) begin $display("FAIL ovr_count: got %0d want 1", xfer_data.size() - n0); n_err++; end
    d = (xfer_data.size() > n0) ? xfer_data[n0] : 32'hx;
    n_vec++; if (d !== 32'h0020_0113) begin $display("FAIL ovr_data: got %h want 00200113", d); n_err++; end
    n_vec++; if (word_addr !== 12'h001) begin $display("FAIL ovr_addr: got %h want 001", word_addr); n_err++; end
    n_vec++; if (word_valid !== 1'b0) begin $display("FAIL ovr_valid0: got %b want 0", word_valid); n_err++; end
  endtask

  task automatic test_glitch;
    int n0;
    logic [31:0] d;
    do_reset();
    n0 = xfer_data.size();
    rx = 1'b0;
    tick(4);
    n_vec++; if (busy !== 1'b1) begin $display("FAIL glitch_busy1: got %b want 1", busy); n_err++; end
    rx = 1'b1;
    tick(20);
    n_vec++; if (busy !== 1'b0) begin $display("FAIL glitch_busy0: got %b want 0", busy); n_err++; end
    send_word(32'hCAFE_F00D);
    tick(4);
    n_vec++; if (xfer_data.size() - n0 !== 1) begin $display("FAIL glitch_count: got %0d want 1", xfer_data.size() - n0); n_err++; end
    d = (xfer_data.size() > n0) ? xfer_data[n0] : 32'hx;
    n_vec++; if (d !== 32'hCAFE_F00D) begin $display("FAIL glitch_data: got %h want cafef00d", d); n_err++; end
  endtask

  task automatic test_frame_err;
    int n0;
    int f0;
    logic [31:0] d;
    logic [11:0] a;
    do_reset();
    n0 = xfer_data.size();
    f0 = fe_cycles;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'hAA, 1'b0);
    n_vec++; if (fe_cycles - f0 !== 1) begin $display("FAIL ferr_pulse: got %0d cycles want 1", fe_cycles - f0); n_err++; end
    n_vec++; if (xfer_data.size() - n0 !== 0) begin $display("FAIL ferr_noword: got %0d want 0", xfer_data.size() - n0); n_err++; end
    n_vec++; if (busy !== 1'b0) begin $display("FAIL ferr_busy: got %b want 0", busy); n_err++; end
    send_word(32'h1122_3344);
    tick(4);
    n_vec++; if (xfer_data.size() - n0 !== 1) begin $display("FAIL ferr_count: got %0d want 1", xfer_data.size() - n0); n_err++; end
    d = (xfer_data.size() > n0) ? xfer_data[n0] : 32'hx;
    a = (xfer_addr.size() > n0) ? xfer_addr[n0] : 12'hx;
    n_vec++; if (d !== 32'h1122_3344) begin $display("FAIL ferr_data: got %h want 11223344", d); n_err++; end
    n_vec++; if (a !== 12'h000) begin $display("FAIL ferr_xaddr: got %h want 000", a); n_err++; end
  endtask

  task automatic test_reset_midframe;
    int n0;
    logic [31:0] d;
    logic [11:0] a;
    logic [7:0]  b;
    do_reset();
    send_word(32'h0020_0113);
    ready = 1'b0;
    send_word(32'h0000_0093);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    b = 8'h55;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[4];
    tick(8);
    n_vec++; if (word_valid !== 1'b1) begin $display("FAIL mid_pre_valid: got %b want 1", word_valid); n_err++; end
    rst = 1'b1;
    tick(2);
    n_vec++; if (word_valid !== 1'b0) begin $display("FAIL mid_valid: got %b want 0", word_valid); n_err++; end
    n_vec++; if (word_data !== 32'h0) begin $display("FAIL mid_data: got %h want 0", word_data); n_err++; end
    n_vec++; if (word_addr !== 12'h0) begin $display("FAIL mid_addr: got %h want 0", word_addr); n_err++; end
    n_vec++; if (busy !== 1'b0) begin $display("FAIL mid_busy: got %b want 0", busy); n_err++; end
    rst = 1'b0;
    rx = 1'b1;
    ready = 1'b1;
    tick(3 * CPB);
    n0 = xfer_data.size();
    send_word(32'hDEAD_BEEF);
    tick(4);
    n_vec++; if (xfer_data.size() - n0 !== 1) begin $display("FAIL mid_count: got %0d want 1", xfer_data.size() - n0); n_err++; end
    d = (xfer_data.size() > n0) ? xfer_data[n0] : 32'hx;
    a = (xfer_addr.size() > n0) ? xfer_addr[n0] : 12'hx;
    n_vec++; if (d !== 32'hDEAD_BEEF) begin $display("FAIL mid_word: got %h want deadbeef", d); n_err++; end
    n_vec++; if (a !== 12'h000) begin $display("FAIL mid_xaddr: got %h want 000", a); n_err++; end
  endtask

  task automatic test_enable;
    int n0;
    int f0;
    logic [31:0] d;
    do_reset();
    n0 = xfer_data.size();
    f0 = fe_cycles;
    en = 1'b0;
    send_word(32'h0020_0113);
    n_vec++; if (xfer_data.size() - n0 !== 0) begin $display("FAIL en_noword: got %0d want 0", xfer_data.size() - n0); n_err++; end
    n_vec++; if (word_valid !== 1'b0) begin $display("FAIL en_valid: got %b want 0", word_valid); n_err++; end
    n_vec++; if (fe_cycles - f0 !== 0) begin $display("FAIL en_ferr: got %0d want 0", fe_cycles - f0); n_err++; end
    n_vec++; if (busy !== 1'b0) begin $display("FAIL en_busy: got %b want 0", busy); n_err++; end
    en = 1'b1;
    tick(4);
    send_word(32'h0000_0093);
    tick(4);
    n_vec++; if (xfer_data.size() - n0 !== 1) begin $display("FAIL en_count: got %0d want 1", xfer_data.size() - n0); n_err++; end
    d = (xfer_data.size() > n0) ? xfer_data[n0] : 32'hx;
    n_vec++; if (d !== 32'h0000_0093) begin $display("FAIL en_data: got %h want 00000093", d); n_err++; end
    ready = 1'b0;
    send_word(32'h1234_5678);
    en = 1'b0;
    tick(10);
    n_vec++; if (word_valid !== 1'b1) begin $display("FAIL en_keep_valid: got %b want 1", word_valid); n_err++; end
    n_vec++; if (word_data !== 32'h1234_5678) begin $display("FAIL en_keep_data: got %h want 12345678", word_data); n_err++; end
    n_vec++; if (word_addr !== 12'h001) begin $display("FAIL en_keep_addr: got %h want 001", word_addr); n_err++; end
    en = 1'b1;
    ready = 1'b1;
    tick(4);
    n_vec++; if (xfer_data.size() - n0 !== 2) begin $display("FAIL en_drain: got %0d want 2", xfer_data.size() - n0); n_err++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
